// File: rtl/rv_id_stage_pkg.sv
// Shared decode definitions for the RV32I decode stage: opcodes, select
// encodings, ALU operation codes and immediate format selector.
package rv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned PC_W  = 30;
    localparam int unsigned REG_W = 5;
    localparam int unsigned ALU_W = 6;

    localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;

    // Major opcodes (IR[6:0])
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // Writeback source
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // ALU operand 1 source
    localparam logic [1:0] OP1_RS1  = 2'b00;
    localparam logic [1:0] OP1_PC   = 2'b01;
    localparam logic [1:0] OP1_ZERO = 2'b10;

    // ALU operation codes
    localparam logic [ALU_W-1:0] ALU_ADD    = 6'd0;
    localparam logic [ALU_W-1:0] ALU_SUB    = 6'd1;
    localparam logic [ALU_W-1:0] ALU_SLL    = 6'd2;
    localparam logic [ALU_W-1:0] ALU_SLT    = 6'd3;
    localparam logic [ALU_W-1:0] ALU_SLTU   = 6'd4;
    localparam logic [ALU_W-1:0] ALU_XOR    = 6'd5;
    localparam logic [ALU_W-1:0] ALU_SRL    = 6'd6;
    localparam logic [ALU_W-1:0] ALU_SRA    = 6'd7;
    localparam logic [ALU_W-1:0] ALU_OR     = 6'd8;
    localparam logic [ALU_W-1:0] ALU_AND    = 6'd9;
    localparam logic [ALU_W-1:0] ALU_EQ     = 6'd16;
    localparam logic [ALU_W-1:0] ALU_NE     = 6'd17;
    localparam logic [ALU_W-1:0] ALU_LT     = 6'd18;
    localparam logic [ALU_W-1:0] ALU_GE     = 6'd19;
    localparam logic [ALU_W-1:0] ALU_LTU    = 6'd20;
    localparam logic [ALU_W-1:0] ALU_GEU    = 6'd21;
    localparam logic [ALU_W-1:0] ALU_MUL    = 6'd32;
    localparam logic [ALU_W-1:0] ALU_MULH   = 6'd33;
    localparam logic [ALU_W-1:0] ALU_MULHSU = 6'd34;
    localparam logic [ALU_W-1:0] ALU_MULHU  = 6'd35;
    localparam logic [ALU_W-1:0] ALU_DIV    = 6'd36;
    localparam logic [ALU_W-1:0] ALU_DIVU   = 6'd37;
    localparam logic [ALU_W-1:0] ALU_REM    = 6'd38;
    localparam logic [ALU_W-1:0] ALU_REMU   = 6'd39;

    // Immediate format selector; IMM_NONE yields zero
    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    // Integer ALU op from funct3; alt selects SUB/SRA over ADD/SRL
    function automatic logic [ALU_W-1:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        logic [ALU_W-1:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Branch comparison op from funct3 (010/011 filtered by caller)
    function automatic logic [ALU_W-1:0] cmp_from_f3(input logic [2:0] f3);
        logic [ALU_W-1:0] op;
        case (f3)
            3'b000:  op = ALU_EQ;
            3'b001:  op = ALU_NE;
            3'b100:  op = ALU_LT;
            3'b101:  op = ALU_GE;
            3'b110:  op = ALU_LTU;
            default: op = ALU_GEU;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv_id_stage_if.sv
// Decode-stage bus: fetch-side inputs and execute-side decoded controls.
// slave = the decode stage, master = surrounding pipeline / testbench.
interface rv_id_stage_if
    import rv_pkg::*;
;
    logic               i_stall;
    logic               i_flush;
    logic [XLEN-1:0]    i_data;
    logic [PC_W-1:0]    i_pc;
    logic [PC_W-1:0]    i_pc_p4;

    logic [REG_W-1:0]   o_rs1;
    logic [REG_W-1:0]   o_rs2;
    logic [REG_W-1:0]   o_rd;
    logic [PC_W-1:0]    o_pc;
    logic [PC_W-1:0]    o_pc_p4;
    logic [XLEN-1:0]    o_imm;
    logic               o_reg_write;
    logic               o_mem_read;
    logic               o_mem_write;
    logic [1:0]         o_res_src;
    logic               o_pc_sel;
    logic               o_jump;
    logic               o_branch;
    logic [1:0]         o_alu_op1_sel;
    logic               o_alu_op2_sel;
    logic [2:0]         o_funct3;
    logic [ALU_W-1:0]   o_alu_ctrl;
    logic               o_inv_instr;

    modport slave (
        input  i_stall, i_flush, i_data, i_pc, i_pc_p4,
        output o_rs1, o_rs2, o_rd, o_pc, o_pc_p4, o_imm,
               o_reg_write, o_mem_read, o_mem_write, o_res_src, o_pc_sel,
               o_jump, o_branch, o_alu_op1_sel, o_alu_op2_sel, o_funct3,
               o_alu_ctrl, o_inv_instr
    );

    modport master (
        output i_stall, i_flush, i_data, i_pc, i_pc_p4,
        input  o_rs1, o_rs2, o_rd, o_pc, o_pc_p4, o_imm,
               o_reg_write, o_mem_read, o_mem_write, o_res_src, o_pc_sel,
               o_jump, o_branch, o_alu_op1_sel, o_alu_op2_sel, o_funct3,
               o_alu_ctrl, o_inv_instr
    );

endinterface

// File: rtl/rv_id_stage_imm_gen.sv
// Immediate generator: builds the sign-extended immediate from IR[31:7]
// according to the instruction format chosen by the decoder.
module rv_imm_gen
    import rv_pkg::*;
(
    input  imm_fmt_e        fmt_i,
    input  logic [31:7]     ir_i,
    output logic [XLEN-1:0] imm_o
);

    // Format-driven immediate assembly
    always_comb begin
        imm_o = '0;
        case (fmt_i)
            IMM_I:   imm_o = {{20{ir_i[31]}}, ir_i[31:20]};
            IMM_S:   imm_o = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
            IMM_B:   imm_o = {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
            IMM_U:   imm_o = {ir_i[31:12], 12'b0};
            IMM_J:   imm_o = {{11{ir_i[31]}}, ir_i[31], ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/rv_id_stage.sv
// RV32I decode stage: instruction register plus combinational decode of
// register indices, immediate and execute/memory/writeback controls.
// Optional M extension decode: define RV_DECODE_M_EXT_EN.
module rv_id_stage
    import rv_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic          i_clk,
    input  logic          i_reset,
    rv_id_stage_if.slave  bus
);

    logic [XLEN-1:0] ir_q,    ir_d;
    logic [PC_W-1:0] pc_q,    pc_d;
    logic [PC_W-1:0] pc_p4_q, pc_p4_d;

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;

    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic [1:0]       res_src;
    logic             pc_sel;
    logic             jump;
    logic             branch;
    logic [1:0]       op1_sel;
    logic             op2_sel;
    logic [ALU_W-1:0] alu_ctrl;
    imm_fmt_e         imm_fmt;
    logic             illegal;

    // Next-state for IR/PC: reset > flush > stall > load
    always_comb begin
        ir_d    = bus.i_data;
        pc_d    = bus.i_pc;
        pc_p4_d = bus.i_pc_p4;
        if (i_reset) begin
            ir_d    = NOP_INSTR;
            pc_d    = '0;
            pc_p4_d = '0;
        end else if (bus.i_flush) begin
            ir_d    = NOP_INSTR;
            pc_d    = pc_q;
            pc_p4_d = pc_p4_q;
        end else if (bus.i_stall) begin
            ir_d    = ir_q;
            pc_d    = pc_q;
            pc_p4_d = pc_p4_q;
        end
    end

    // Instruction/PC register
    always_ff @(posedge i_clk) begin
        ir_q    <= ir_d;
        pc_q    <= pc_d;
        pc_p4_q <= pc_p4_d;
    end

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];
    assign funct7 = ir_q[31:25];

    // Opcode decode; any illegal encoding collapses back to safe defaults
    always_comb begin
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        res_src   = RES_ALU;
        pc_sel    = 1'b0;
        jump      = 1'b0;
        branch    = 1'b0;
        op1_sel   = OP1_RS1;
        op2_sel   = 1'b0;
        alu_ctrl  = ALU_ADD;
        imm_fmt   = IMM_NONE;
        illegal   = 1'b0;

        case (opcode)
            OPC_LUI: begin
                reg_write = 1'b1;
                op1_sel   = OP1_ZERO;
                op2_sel   = 1'b1;
                imm_fmt   = IMM_U;
            end
            OPC_AUIPC: begin
                reg_write = 1'b1;
                op1_sel   = OP1_PC;
                op2_sel   = 1'b1;
                imm_fmt   = IMM_U;
            end
            OPC_JAL: begin
                reg_write = 1'b1;
                jump      = 1'b1;
                res_src   = RES_PC4;
                imm_fmt   = IMM_J;
            end
            OPC_JALR: begin
                reg_write = 1'b1;
                jump      = 1'b1;
                res_src   = RES_PC4;
                pc_sel    = 1'b1;
                op2_sel   = 1'b1;
                imm_fmt   = IMM_I;
                illegal   = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                branch   = 1'b1;
                alu_ctrl = cmp_from_f3(funct3);
                imm_fmt  = IMM_B;
                illegal  = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_LOAD: begin
                reg_write = 1'b1;
                mem_read  = 1'b1;
                res_src   = RES_MEM;
                op2_sel   = 1'b1;
                imm_fmt   = IMM_I;
                illegal   = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                mem_write = 1'b1;
                op2_sel   = 1'b1;
                imm_fmt   = IMM_S;
                illegal   = (funct3[2] == 1'b1) || (funct3 == 3'b011);
            end
            OPC_OP_IMM: begin
                reg_write = 1'b1;
                op2_sel   = 1'b1;
                imm_fmt   = IMM_I;
                alu_ctrl  = alu_from_f3(funct3, (funct3 == 3'b101) && ir_q[30]);
                if (funct3 == 3'b001) begin
                    illegal = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                end
            end
            OPC_OP: begin
                reg_write = 1'b1;
                case (funct7)
                    7'b0000000: alu_ctrl = alu_from_f3(funct3, 1'b0);
                    7'b0100000: begin
                        alu_ctrl = alu_from_f3(funct3, 1'b1);
                        illegal  = (funct3 != 3'b000) && (funct3 != 3'b101);
                    end
`ifdef RV_DECODE_M_EXT_EN
                    7'b0000001: alu_ctrl = ALU_MUL | {3'b000, funct3};
`endif
                    default:    illegal = 1'b1;
                endcase
            end
            OPC_MISC_MEM: begin
                // FENCE is a no-op in this in-order pipeline
            end
            default: illegal = 1'b1;
        endcase

        if (illegal) begin
            reg_write = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            res_src   = RES_ALU;
            pc_sel    = 1'b0;
            jump      = 1'b0;
            branch    = 1'b0;
            op1_sel   = OP1_RS1;
            op2_sel   = 1'b0;
            alu_ctrl  = ALU_ADD;
            imm_fmt   = IMM_NONE;
        end
    end

    rv_imm_gen u_imm_gen (
        .fmt_i (imm_fmt),
        .ir_i  (ir_q[31:7]),
        .imm_o (bus.o_imm)
    );

    assign bus.o_rs1         = ir_q[19:15];
    assign bus.o_rs2         = ir_q[24:20];
    assign bus.o_rd          = ir_q[11:7];
    assign bus.o_pc          = pc_q;
    assign bus.o_pc_p4       = pc_p4_q;
    assign bus.o_funct3      = funct3;
    assign bus.o_reg_write   = reg_write;
    assign bus.o_mem_read    = mem_read;
    assign bus.o_mem_write   = mem_write;
    assign bus.o_res_src     = res_src;
    assign bus.o_pc_sel      = pc_sel;
    assign bus.o_jump        = jump;
    assign bus.o_branch      = branch;
    assign bus.o_alu_op1_sel = op1_sel;
    assign bus.o_alu_op2_sel = op2_sel;
    assign bus.o_alu_ctrl    = alu_ctrl;
    assign bus.o_inv_instr   = illegal;

endmodule

// File: tb/tb_rv_id_stage.sv
// Directed bench for rv_id_stage with hand-computed decode expectations.
module tb_rv_id_stage;
    import rv_pkg::*;

    logic clk;
    logic rst;
    int   vec_cnt;
    int   err_cnt;

    rv_id_stage_if id_if ();

    rv_id_stage dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (id_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the edge
    task automatic step(input logic [31:0] data, input logic [29:0] pc,
                        input logic stall, input logic flush);
        id_if.i_data  = data;
        id_if.i_pc    = pc;
        id_if.i_pc_p4 = pc + 30'd1;
        id_if.i_stall = stall;
        id_if.i_flush = flush;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_we(input string tag, input logic rw, input logic mr,
                          input logic mw, input logic j, input logic b);
        chk({tag, ".reg_write"}, 32'(id_if.o_reg_write), 32'(rw));
        chk({tag, ".mem_read"},  32'(id_if.o_mem_read),  32'(mr));
        chk({tag, ".mem_write"}, 32'(id_if.o_mem_write), 32'(mw));
        chk({tag, ".jump"},      32'(id_if.o_jump),      32'(j));
        chk({tag, ".branch"},    32'(id_if.o_branch),    32'(b));
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst = 1'b1;
        step(32'hFFFF_FFFF, 30'h3FFF_FFF0, 1'b0, 1'b0);
        step(32'hFFFF_FFFF, 30'h3FFF_FFF0, 1'b1, 1'b1);
        chk("rst.rd",       32'(id_if.o_rd), 32'd0);
        chk("rst.alu",      32'(id_if.o_alu_ctrl), 32'(ALU_ADD));
        chk("rst.op2",      32'(id_if.o_alu_op2_sel), 32'd1);
        chk("rst.inv",      32'(id_if.o_inv_instr), 32'd0);
        chk("rst.pc",       32'(id_if.o_pc), 32'd0);
        chk("rst.pc_p4",    32'(id_if.o_pc_p4), 32'd0);
        chk("rst.imm",      id_if.o_imm, 32'd0);
        chk_we("rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // addi x1,x0,5
        step(32'h0050_0093, 30'h10, 1'b0, 1'b0);
        chk("addi.rd",  32'(id_if.o_rd), 32'd1);
        chk("addi.rs1", 32'(id_if.o_rs1), 32'd0);
        chk("addi.imm", id_if.o_imm, 32'd5);
        chk("addi.op2", 32'(id_if.o_alu_op2_sel), 32'd1);
        chk("addi.alu", 32'(id_if.o_alu_ctrl), 32'(ALU_ADD));
        chk("addi.pc",  32'(id_if.o_pc), 32'h10);
        chk("addi.pc4", 32'(id_if.o_pc_p4), 32'h11);
        chk_we("addi", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // lw x2,8(x1)
        step(32'h0080_A103, 30'h11, 1'b0, 1'b0);
        chk("lw.rd",   32'(id_if.o_rd), 32'd2);
        chk("lw.rs1",  32'(id_if.o_rs1), 32'd1);
        chk("lw.res",  32'(id_if.o_res_src), 32'd1);
        chk("lw.f3",   32'(id_if.o_funct3), 32'd2);
        chk("lw.imm",  id_if.o_imm, 32'd8);
        chk("lw.alu",  32'(id_if.o_alu_ctrl), 32'(ALU_ADD));
        chk_we("lw", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // sw x2,-4(x1)
        step(32'hFE20_AE23, 30'h12, 1'b0, 1'b0);
        chk("sw.rs1", 32'(id_if.o_rs1), 32'd1);
        chk("sw.rs2", 32'(id_if.o_rs2), 32'd2);
        chk("sw.imm", id_if.o_imm, 32'hFFFF_FFFC);
        chk_we("sw", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // jal x1,+8
        step(32'h0080_00EF, 30'h13, 1'b0, 1'b0);
        chk("jal.rd",     32'(id_if.o_rd), 32'd1);
        chk("jal.res",    32'(id_if.o_res_src), 32'd2);
        chk("jal.pc_sel", 32'(id_if.o_pc_sel), 32'd0);
        chk("jal.imm",    id_if.o_imm, 32'd8);
        chk_we("jal", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // bne x1,x2,-4
        step(32'hFE20_9EE3, 30'h14, 1'b0, 1'b0);
        chk("bne.alu", 32'(id_if.o_alu_ctrl), 32'd17);
        chk("bne.imm", id_if.o_imm, 32'hFFFF_FFFC);
        chk("bne.op2", 32'(id_if.o_alu_op2_sel), 32'd0);
        chk("bne.inv", 32'(id_if.o_inv_instr), 32'd0);
        chk_we("bne", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // lui x5,0x12345
        step(32'h1234_52B7, 30'h15, 1'b0, 1'b0);
        chk("lui.rd",  32'(id_if.o_rd), 32'd5);
        chk("lui.imm", id_if.o_imm, 32'h1234_5000);
        chk("lui.op1", 32'(id_if.o_alu_op1_sel), 32'd2);
        chk("lui.op2", 32'(id_if.o_alu_op2_sel), 32'd1);

        // sub x3,x1,x2
        step(32'h4020_81B3, 30'h16, 1'b0, 1'b0);
        chk("sub.alu", 32'(id_if.o_alu_ctrl), 32'd1);
        chk("sub.op2", 32'(id_if.o_alu_op2_sel), 32'd0);
        chk("sub.imm", id_if.o_imm, 32'd0);
        chk("sub.inv", 32'(id_if.o_inv_instr), 32'd0);

        // srai x1,x1,3 (legal) then slli with funct7=0100000 (illegal)
        step(32'h4030_D093, 30'h17, 1'b0, 1'b0);
        chk("srai.alu", 32'(id_if.o_alu_ctrl), 32'd7);
        chk("srai.inv", 32'(id_if.o_inv_instr), 32'd0);
        step(32'h4030_9093, 30'h18, 1'b0, 1'b0);
        chk("slli_bad.inv", 32'(id_if.o_inv_instr), 32'd1);
        chk_we("slli_bad", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // mul x3,x1,x2: legal only with the M extension
        step(32'h0220_81B3, 30'h19, 1'b0, 1'b0);
`ifdef RV_DECODE_M_EXT_EN
        chk("mul.inv", 32'(id_if.o_inv_instr), 32'd0);
        chk("mul.alu", 32'(id_if.o_alu_ctrl), 32'd32);
        chk("mul.rw",  32'(id_if.o_reg_write), 32'd1);
`else
        chk("mul.inv", 32'(id_if.o_inv_instr), 32'd1);
        chk("mul.rw",  32'(id_if.o_reg_write), 32'd0);
`endif

        // all-ones word: unknown opcode
        step(32'hFFFF_FFFF, 30'h1A, 1'b0, 1'b0);
        chk("ones.inv", 32'(id_if.o_inv_instr), 32'd1);
        chk("ones.imm", id_if.o_imm, 32'd0);
        chk_we("ones", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // stall holds IR and PC
        step(32'h0050_0093, 30'h20, 1'b0, 1'b0);
        step(32'hFE20_AE23, 30'h30, 1'b1, 1'b0);
        chk("stall.rd",   32'(id_if.o_rd), 32'd1);
        chk("stall.imm",  id_if.o_imm, 32'd5);
        chk("stall.pc",   32'(id_if.o_pc), 32'h20);
        chk("stall.pc4",  32'(id_if.o_pc_p4), 32'h21);
        chk_we("stall", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // flush beats stall: NOP in IR, PC kept
        step(32'h0080_00EF, 30'h40, 1'b1, 1'b1);
        chk("flush.rd",   32'(id_if.o_rd), 32'd0);
        chk("flush.imm",  id_if.o_imm, 32'd0);
        chk("flush.pc",   32'(id_if.o_pc), 32'h20);
        chk("flush.inv",  32'(id_if.o_inv_instr), 32'd0);
        chk_we("flush", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/rv_id_stage.md
Name: rv_id_stage

Overview:
- RV32I instruction-decode stage of the five-stage core; sits between fetch and execute.
- Captures the fetched instruction word and its PC/PC+4 into an instruction register (IR).
- Decodes the IR combinationally into register indices, a sign-extended immediate and execute/memory/writeback control.
- Flags unsupported encodings so the core sequencer holds in DECODE.

Parameters:
- NOP_INSTR, 32'h0000_0013, word loaded into the IR on reset/flush (addi x0,x0,0).

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  synchronous reset, active-high.
- i_stall  in  1  hold IR and PC registers.
- i_flush  in  1  load NOP_INSTR into IR.
- i_data  in  32  fetched instruction word.
- i_pc  in  30  [31:2] PC of i_data.
- i_pc_p4  in  30  [31:2] PC+4 of i_data.
- o_rs1, o_rs2, o_rd  out  5 each  IR[19:15], IR[24:20], IR[11:7], always passed raw.
- o_pc, o_pc_p4  out  30 each  registered PC/PC+4.
- o_imm  out  32  sign-extended immediate.
- o_reg_write  out  1  instruction writes rd.
- o_mem_read, o_mem_write  out  1 each  load / store.
- o_res_src  out  2  writeback source: 00 ALU, 01 memory, 10 PC+4.
- o_pc_sel  out  1  jump target base: 0 PC (JAL, branch), 1 rs1 (JALR).
- o_jump, o_branch  out  1 each  unconditional jump / conditional branch.
- o_alu_op1_sel  out  2  ALU operand 1: 00 rs1, 01 PC, 10 zero.
- o_alu_op2_sel  out  1  ALU operand 2: 0 rs2, 1 imm.
- o_funct3  out  3  IR[14:12].
- o_alu_ctrl  out  6  ALU operation code (package constants).
- o_inv_instr  out  1  unsupported or illegal encoding.

Behaviour:
- Register update, one per rising edge, priority order:
  - i_reset: IR=NOP_INSTR, pc=0, pc_p4=0.
  - else i_flush: IR=NOP_INSTR, pc/pc_p4 unchanged.
  - else i_stall: hold all registers.
  - else: load i_data, i_pc, i_pc_p4.
- Latency: all outputs are combinational from the registered state, valid in the cycle after capture. No internal FSM.
- Immediate formats:
  - I: {20{IR[31]},IR[31:20]}.
  - S: {20{IR[31]},IR[31:25],IR[11:7]}.
  - B: {19{IR[31]},IR[31],IR[7],IR[30:25],IR[11:8],0}.
  - U: {IR[31:12],12'b0}.
  - J: {11{IR[31]},IR[31],IR[19:12],IR[20],IR[30:21],0}.
  - R-type and invalid: 0.
- Opcode decode (everything not listed is 0; default o_alu_ctrl = ADD):
  - LUI: reg_write; op1 zero; op2 imm.
  - AUIPC: reg_write; op1 PC; op2 imm.
  - JAL: reg_write, jump, res_src 10, pc_sel 0.
  - JALR (funct3=000 required): reg_write, jump, res_src 10, pc_sel 1, op2 imm.
  - BRANCH (funct3 010/011 invalid): branch, pc_sel 0, op2 rs2, alu_ctrl = comparison from funct3 (EQ, NE, LT, GE, LTU, GEU).
  - LOAD (funct3 000,001,010,100,101 only): reg_write, mem_read, res_src 01, op2 imm, ADD.
  - STORE (funct3 000–010 only): mem_write, op2 imm, ADD.
  - OP-IMM: reg_write, op2 imm, alu_ctrl from funct3. SLLI needs IR[31:25]=0. SRLI/SRAI need IR[31:25] of 0000000/0100000.
  - OP: reg_write, op2 rs2, alu_ctrl from funct3 and IR[30]. Only funct7 values 0000000 and 0100000 (the latter for SUB/SRA only) are legal.
  - MISC-MEM (FENCE): decoded as NOP, valid.
  - SYSTEM and any other opcode, or IR[1:0]≠11: o_inv_instr=1, and reg_write, mem_read, mem_write, jump and branch forced to 0.

Optional Feature:
- Macro RV_DECODE_M_EXT_EN.
- Defined: OP with funct7=0000001 decodes to MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU by funct3, with reg_write=1.
- Undefined: that encoding sets o_inv_instr=1.

Decomposition:
- Package rv_pkg holds:
  - opcode localparams;
  - res_src and op1_sel encodings;
  - alu_ctrl constants: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, EQ=16, NE=17, LT=18, GE=19, LTU=20, GEU=21, MUL..REMU=32..39.
- One sub-module, rv_imm_gen: IR to o_imm by format.

Test Plan:
- Reset with i_data=0xFFFFFFFF: IR=NOP, o_rd=0, o_alu_ctrl=ADD, o_alu_op2_sel=1, o_inv_instr=0, o_pc=0.
- Load 0x00500093 (addi x1,x0,5): o_rd=1, o_rs1=0, o_imm=5, reg_write=1, op2_sel=1, ADD.
- Load 0x0080A103 (lw x2,8(x1)): mem_read=1, res_src=01, funct3=010, imm=8.
- Load 0xFE20AE23 (sw x2,-4(x1)): mem_write=1, reg_write=0, rs1=1, rs2=2, imm=0xFFFFFFFC.
- Load 0x008000EF (jal x1,+8): jump=1, res_src=10, pc_sel=0, imm=8.
- Load 0xFFFFFFFF: o_inv_instr=1, all write enables 0.
- Stall/flush:
  - i_stall=1 with new i_data: outputs unchanged.
  - i_stall=1 and i_flush=1: flush wins, IR=NOP.
